// File: rtl/cu_fsm.sv
// OTTER control-unit sequencer: INIT -> FETCH -> EXEC [-> WB] -> FETCH, plus retire counter.
// Define CU_INTR_EN to add the one-cycle INTR entry state driven by FSM_intr & FSM_mie.
module cu_fsm #(
   parameter int RESET_CYCLES = 2,
   parameter int INSTRET_W    = 32
) (
   input  logic                 FSM_clk,
   input  logic                 FSM_rst_n,
   input  logic [6:0]           FSM_opcode,
   input  logic                 FSM_memRdy,
   input  logic                 FSM_intr,
   input  logic                 FSM_mie,
   output logic                 FSM_rst,
   output logic                 FSM_pcWrite,
   output logic                 FSM_regWrite,
   output logic                 FSM_memWE2,
   output logic                 FSM_memRDEN1,
   output logic                 FSM_memRDEN2,
   output logic                 FSM_illegal,
   output logic                 FSM_intTaken,
   output logic [INSTRET_W-1:0] FSM_instret
);

   localparam int              CW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [CW-1:0]   INIT_LAST = CW'(RESET_CYCLES - 1);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;

   typedef enum logic [2:0] {
      INIT,
      FETCH,
      EXEC,
      WB
`ifdef CU_INTR_EN
      , INTR
`endif
   } state_t;

   state_t                 r_state, w_next, w_after;
   logic [CW-1:0]          r_initCnt;
   logic [INSTRET_W-1:0]   r_instret;
   logic                   w_pend, w_retire;
   logic                   w_rst, w_pcWrite, w_regWrite, w_memWE2;
   logic                   w_memRDEN1, w_memRDEN2, w_illegal, w_intTaken;

`ifdef CU_INTR_EN
   assign w_pend = FSM_intr & FSM_mie;
`else
   logic w_unused;
   assign w_unused = FSM_intr ^ FSM_mie;
   assign w_pend   = 1'b0;
`endif

   // Destination after a retiring cycle (EXEC non-load, or WB completion).
   always_comb begin
      w_after = FETCH;
`ifdef CU_INTR_EN
      if (w_pend) w_after = INTR;
`endif
   end

   always_ff @(posedge FSM_clk or negedge FSM_rst_n) begin
      if (!FSM_rst_n) begin
         r_state   <= INIT;
         r_initCnt <= '0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == INIT && r_initCnt != INIT_LAST) r_initCnt <= r_initCnt + 1'b1;
         if (w_retire) r_instret <= r_instret + 1'b1;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_rst      = 1'b0;
      w_pcWrite  = 1'b0;
      w_regWrite = 1'b0;
      w_memWE2   = 1'b0;
      w_memRDEN1 = 1'b0;
      w_memRDEN2 = 1'b0;
      w_illegal  = 1'b0;
      w_intTaken = 1'b0;
      case (r_state)
         INIT: begin
            w_rst = 1'b1;
            if (r_initCnt == INIT_LAST) w_next = FETCH;
         end
         FETCH: begin
            w_memRDEN1 = 1'b1;
            w_next     = EXEC;
         end
         EXEC: begin
            w_next = w_after;
            case (FSM_opcode)
               OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR: begin
                  w_pcWrite  = 1'b1;
                  w_regWrite = 1'b1;
               end
               OP_BR: w_pcWrite = 1'b1;
               OP_ST: begin
                  w_memWE2  = 1'b1;
                  w_pcWrite = 1'b1;
               end
               OP_LD: begin
                  w_memRDEN2 = 1'b1;
                  w_next     = WB;
               end
               // Unknown opcodes are skipped over but still retire.
               default: begin
                  w_illegal = 1'b1;
                  w_pcWrite = 1'b1;
               end
            endcase
         end
         WB: begin
            if (FSM_memRdy) begin
               w_regWrite = 1'b1;
               w_pcWrite  = 1'b1;
               w_next     = w_after;
            end
         end
`ifdef CU_INTR_EN
         INTR: begin
            w_intTaken = 1'b1;
            w_pcWrite  = 1'b1;
            w_next     = FETCH;
         end
`endif
         default: w_next = INIT;
      endcase
   end

   assign w_retire     = w_pcWrite & ((r_state == EXEC) | (r_state == WB));

   assign FSM_rst      = w_rst;
   assign FSM_pcWrite  = w_pcWrite;
   assign FSM_regWrite = w_regWrite;
   assign FSM_memWE2   = w_memWE2;
   assign FSM_memRDEN1 = w_memRDEN1;
   assign FSM_memRDEN2 = w_memRDEN2;
   assign FSM_illegal  = w_illegal;
   assign FSM_intTaken = w_intTaken;
   assign FSM_instret  = r_instret;

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: an instruction-level model queues the expected per-cycle
// enables; a negedge monitor pops and compares. Narrow instret (4 bits) exercises wrap.
module tb_cu_fsm;
   localparam int IW = 4;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;

   // expected enable vector: {rst,pcWrite,regWrite,memWE2,memRDEN1,memRDEN2,illegal,intTaken}
   localparam logic [7:0] S_RST  = 8'b1000_0000;
   localparam logic [7:0] S_FET  = 8'b0000_1000;
   localparam logic [7:0] S_NONE = 8'b0000_0000;
   localparam logic [7:0] S_INT  = 8'b0100_0001;
   localparam logic [7:0] S_WBOK = 8'b0110_0000;

   logic          FSM_clk = 1'b0;
   logic          FSM_rst_n = 1'b0;
   logic [6:0]    FSM_opcode = '0;
   logic          FSM_memRdy = 1'b0, FSM_intr = 1'b0, FSM_mie = 1'b0;
   logic          FSM_rst, FSM_pcWrite, FSM_regWrite, FSM_memWE2;
   logic          FSM_memRDEN1, FSM_memRDEN2, FSM_illegal, FSM_intTaken;
   logic [IW-1:0] FSM_instret;

   cu_fsm #(.RESET_CYCLES(2), .INSTRET_W(IW)) dut (
      .FSM_clk(FSM_clk), .FSM_rst_n(FSM_rst_n), .FSM_opcode(FSM_opcode),
      .FSM_memRdy(FSM_memRdy), .FSM_intr(FSM_intr), .FSM_mie(FSM_mie),
      .FSM_rst(FSM_rst), .FSM_pcWrite(FSM_pcWrite), .FSM_regWrite(FSM_regWrite),
      .FSM_memWE2(FSM_memWE2), .FSM_memRDEN1(FSM_memRDEN1), .FSM_memRDEN2(FSM_memRDEN2),
      .FSM_illegal(FSM_illegal), .FSM_intTaken(FSM_intTaken), .FSM_instret(FSM_instret)
   );

   always #5 FSM_clk = ~FSM_clk;

   logic [7+IW:0] q_exp[$];
   string         q_tag[$];
   int            total = 0, bad = 0;
   logic [IW-1:0] cnt = '0;     // retired-instruction count, wraps mod 2^IW
   bit            intr_en;

   function automatic logic [7+IW:0] ex(input logic [7:0] s);
      return {s, cnt};
   endfunction

   function automatic logic [7:0] exec_sig(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR: return 8'b0110_0000;
         OP_BR:   return 8'b0100_0000;
         OP_ST:   return 8'b0101_0000;
         OP_LD:   return 8'b0000_0100;
         default: return 8'b0100_0010;
      endcase
   endfunction

   // One DUT cycle: drive inputs just after the edge, queue what that cycle must show.
   task automatic step(input logic rn, input logic [6:0] op, input logic rdy,
                       input logic it, input logic mi, input logic [7+IW:0] e, input string tag);
      @(posedge FSM_clk); #1;
      FSM_rst_n = rn; FSM_opcode = op; FSM_memRdy = rdy; FSM_intr = it; FSM_mie = mi;
      q_exp.push_back(e);
      q_tag.push_back(tag);
   endtask

   task automatic release_reset();
      cnt = '0;
      step(1'b1, 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ex(S_RST), "init1");
      step(1'b1, 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ex(S_RST), "init2");
   endtask

   task automatic do_instr(input logic [6:0] op, input int stalls, input logic it, input logic mi);
      step(1'b1, 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ex(S_FET), "fetch");
      if (op == OP_LD) begin
         step(1'b1, op, 1'($urandom), 1'($urandom), 1'($urandom), ex(exec_sig(op)), "exec_ld");
         for (int s = 0; s < stalls; s++)
            step(1'b1, op, 1'b0, 1'($urandom), 1'($urandom), ex(S_NONE), "wb_stall");
         step(1'b1, op, 1'b1, it, mi, ex(S_WBOK), "wb_done");
      end else begin
         step(1'b1, op, 1'($urandom), it, mi, ex(exec_sig(op)), "exec");
      end
      cnt = cnt + 1'b1;
      if (intr_en && it && mi)
         step(1'b1, 7'($urandom), 1'($urandom), 1'b0, 1'b0, ex(S_INT), "intr");
   endtask

   always @(negedge FSM_clk) begin
      logic [7+IW:0] e, got;
      string         t;
      if (q_exp.size() > 0) begin
         e   = q_exp.pop_front();
         t   = q_tag.pop_front();
         got = {FSM_rst, FSM_pcWrite, FSM_regWrite, FSM_memWE2, FSM_memRDEN1,
                FSM_memRDEN2, FSM_illegal, FSM_intTaken, FSM_instret};
         total++;
         if (got !== e) begin
            bad++;
            $display("FAIL %s got=%b want=%b (rst,pcW,regW,memWE2,RDEN1,RDEN2,ill,intT,instret)",
                     t, got, e);
         end
         total++;
         if ($countones({FSM_memWE2, FSM_memRDEN2, FSM_memRDEN1}) > 1) begin
            bad++;
            $display("FAIL mem_onehot got=%b want=at most one set",
                     {FSM_memWE2, FSM_memRDEN2, FSM_memRDEN1});
         end
      end
   end

   initial begin
      logic [6:0] ops[9];
      logic [6:0] op;
`ifdef CU_INTR_EN
      intr_en = 1'b1;
`else
      intr_en = 1'b0;
`endif
      ops = '{OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR, OP_BR, OP_ST, OP_LD};

      step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, ex(S_RST), "in_reset");
      step(1'b0, OP_IMM, 1'b1, 1'b1, 1'b1, ex(S_RST), "in_reset");
      release_reset();

      do_instr(OP_IMM, 0, 1'b0, 1'b0);
      do_instr(OP_LD, 3, 1'b0, 1'b0);
      do_instr(OP_ST, 0, 1'b0, 1'b0);
      do_instr(7'h7F, 0, 1'b0, 1'b0);
      do_instr(OP_IMM, 0, 1'b1, 1'b1);
      do_instr(OP_IMM, 0, 1'b1, 1'b0);
      do_instr(OP_LD, 2, 1'b1, 1'b1);
      do_instr(OP_BR, 0, 1'b0, 1'b0);

      // reset pulled during a WB stall with memRdy high: no regWrite may leak out
      do_instr(OP_JAL, 0, 1'b0, 1'b0);
      step(1'b1, 7'($urandom), 1'b0, 1'b0, 1'b0, ex(S_FET), "fetch");
      step(1'b1, OP_LD, 1'b0, 1'b0, 1'b0, ex(exec_sig(OP_LD)), "exec_ld");
      step(1'b1, OP_LD, 1'b0, 1'b0, 1'b0, ex(S_NONE), "wb_stall");
      cnt = '0;
      step(1'b0, OP_LD, 1'b1, 1'b1, 1'b1, ex(S_RST), "rst_in_wb");
      release_reset();

      for (int n = 0; n < 20; n++) do_instr(OP_REG, 0, 1'b0, 1'b0);

      for (int n = 0; n < 250; n++) begin
         int k;
         k  = $urandom_range(0, 9);
         op = (k == 9) ? 7'($urandom) : ops[k];
         do_instr(op, $urandom_range(0, 4), 1'($urandom), 1'($urandom));
      end

      @(negedge FSM_clk);
      @(negedge FSM_clk);
      total++;
      if (q_exp.size() != 0) begin
         bad++;
         $display("FAIL queue_drain got=%0d want=0", q_exp.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
